// File: rtl/flash_read_master.sv
// flash_read_master
// Avalon-MM read master that fetches one 32-bit flash word per request pulse
// and hands it downstream with a one-cycle read_data_flag strobe. Requests
// that arrive while a read is in flight are held in a single pending slot
// (latest address wins) and issued as soon as the current read completes.
// A read that never returns readdatavalid is abandoned after TIMEOUT_CYCLES
// cycles: it returns zero data, still pulses the flag, and sets a sticky error.

module flash_read_master #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk50M,
    input  logic              reset,
    input  logic              read_addr_flag,
    input  logic [ADDR_W-1:0] current_address,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [DATA_W-1:0] flash_data,
    output logic              read_data_flag,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_VALID = 2'd2
    } state_t;

    state_t             state;
    logic               pending;
    logic [ADDR_W-1:0]  pending_address;
    logic [CNT_W-1:0]   timeout_count;

    logic               wait_done;
    logic               serve_next;
    logic [ADDR_W-1:0]  next_address;

    // Whole words are always fetched.
    assign flash_mem_byteenable = 4'hF;
    assign busy                 = (state != IDLE);

    // The read finishes on returned data, or when the counter reaches its last
    // allowed value without data (data takes priority in the same cycle).
    assign wait_done = flash_mem_readdatavalid ||
                       (timeout_count == CNT_W'(TIMEOUT_CYCLES - 1));

    // A request landing in the completion cycle counts as the newest pending
    // request, so it overrides an older pending address.
    assign serve_next   = pending || read_addr_flag;
    assign next_address = read_addr_flag ? current_address : pending_address;

    // Read handshake sequencer with pending slot, timeout and registered outputs.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            flash_mem_read    <= 1'b0;
            flash_mem_address <= '0;
            flash_data        <= '0;
            read_data_flag    <= 1'b0;
            pending           <= 1'b0;
            pending_address   <= '0;
            timeout_count     <= '0;
            timeout_err       <= 1'b0;
        end else begin
            read_data_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_addr_flag) begin
                        flash_mem_address <= current_address;
                        flash_mem_read    <= 1'b1;
                        state             <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (read_addr_flag) begin
                        pending         <= 1'b1;
                        pending_address <= current_address;
                    end
                    // Address and read stay frozen until the slave accepts.
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        timeout_count  <= '0;
                        state          <= WAIT_VALID;
                    end
                end

                WAIT_VALID: begin
                    if (wait_done) begin
                        read_data_flag <= 1'b1;
                        if (flash_mem_readdatavalid) begin
                            flash_data <= flash_mem_readdata;
                        end else begin
                            flash_data  <= '0;
                            timeout_err <= 1'b1;
                        end
                        if (serve_next) begin
                            flash_mem_address <= next_address;
                            flash_mem_read    <= 1'b1;
                            pending           <= 1'b0;
                            state             <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                        if (read_addr_flag) begin
                            pending         <= 1'b1;
                            pending_address <= current_address;
                        end
                    end
                end

                default: begin
                    flash_mem_read <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_master.sv
// Testbench for flash_read_master: the bench plays the Avalon flash slave and
// the request source, and predicts every output from a transaction-level view
// (one read in flight, one pending slot, slave-side accept/return events).

module tb_flash_read_master;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int TMO    = 1024;

    logic              clk50M = 1'b0;
    logic              reset;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              vld;
    logic [DATA_W-1:0] rdata;

    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic [DATA_W-1:0] flash_data;
    logic              read_data_flag;
    logic              busy;
    logic              timeout_err;

    flash_read_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk50M                 (clk50M),
        .reset                  (reset),
        .read_addr_flag         (req),
        .current_address        (addr),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_waitrequest  (wr),
        .flash_mem_readdata     (rdata),
        .flash_mem_readdatavalid(vld),
        .flash_data             (flash_data),
        .read_data_flag         (read_data_flag),
        .busy                   (busy),
        .timeout_err            (timeout_err)
    );

    always #10 clk50M = ~clk50M;

    int checks = 0;
    int passes = 0;
    int n_flag = 0;

    // Reference model state
    logic              m_inflight;   // a read is owned by the master
    logic              m_cmd_open;   // command presented, not yet accepted
    logic [ADDR_W-1:0] m_cmd_addr;
    logic              m_outst;      // accepted, awaiting data
    int                m_wait;       // edges spent waiting for data
    logic              m_pend;
    logic [ADDR_W-1:0] m_pend_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_terr;
    logic              m_flag;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic m_clear();
        m_inflight  = 1'b0;
        m_cmd_open  = 1'b0;
        m_cmd_addr  = '0;
        m_outst     = 1'b0;
        m_wait      = 0;
        m_pend      = 1'b0;
        m_pend_addr = '0;
        m_data      = '0;
        m_terr      = 1'b0;
        m_flag      = 1'b0;
    endtask

    task automatic check_outputs();
        check("flag", read_data_flag, m_flag);
        check("data", flash_data, m_data);
        check("busy", busy, m_inflight);
        check("read", flash_mem_read, m_cmd_open);
        check("terr", timeout_err, m_terr);
        if (m_cmd_open) check("addr", flash_mem_address, m_cmd_addr);
    endtask

    // One clock edge: update the model with what happened at the edge, compare.
    task automatic step();
        logic comp, tmo, acc;
        logic [DATA_W-1:0] cdata;
        @(posedge clk50M);
        #1;
        if (reset) begin
            m_clear();
        end else begin
            comp  = 1'b0;
            tmo   = 1'b0;
            cdata = '0;
            acc   = m_cmd_open && !wr;
            if (m_outst) begin
                m_wait++;
                if (vld) begin
                    comp  = 1'b1;
                    cdata = rdata;
                end else if (m_wait == TMO) begin
                    comp = 1'b1;
                    tmo  = 1'b1;
                end
            end
            if (req) begin
                if (m_inflight) begin
                    m_pend      = 1'b1;
                    m_pend_addr = addr;
                end else begin
                    m_inflight = 1'b1;
                    m_cmd_open = 1'b1;
                    m_cmd_addr = addr;
                end
            end
            if (acc) begin
                m_cmd_open = 1'b0;
                m_outst    = 1'b1;
                m_wait     = 0;
            end
            m_flag = comp;
            if (comp) begin
                m_outst = 1'b0;
                m_data  = cdata;
                if (tmo) m_terr = 1'b1;
                if (m_pend) begin
                    m_cmd_open = 1'b1;
                    m_cmd_addr = m_pend_addr;
                    m_pend     = 1'b0;
                end else begin
                    m_inflight = 1'b0;
                end
            end
        end
        check_outputs();
        if (read_data_flag) n_flag++;
    endtask

    task automatic do_reset();
        req   = 1'b0;
        vld   = 1'b0;
        wr    = 1'b0;
        reset = 1'b1;
        #2;
        m_clear();
        check_outputs();
        check("byteenable", flash_mem_byteenable, 4'hF);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int f0;
        reset = 1'b0;
        req   = 1'b0;
        addr  = '0;
        wr    = 1'b0;
        vld   = 1'b0;
        rdata = '0;
        m_clear();
        #5;
        do_reset();

        // T1: zero-wait read, data one cycle after accept, 3-cycle latency
        f0 = n_flag;
        req = 1'b1; addr = 23'h000010; wr = 1'b0;
        step();
        req = 1'b0;
        check("t1_addr", flash_mem_address, 23'h10);
        step();
        vld = 1'b1; rdata = 32'hBBBBAAAA;
        step();
        vld = 1'b0;
        check("t1_flag", read_data_flag, 1'b1);
        check("t1_data", flash_data, 32'hBBBBAAAA);
        step();
        check("t1_flag_once", read_data_flag, 1'b0);
        check("t1_pulses", n_flag - f0, 1);

        // T2: waitrequest held five edges
        req = 1'b1; addr = 23'h2ABCDE; wr = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t2_read_held", flash_mem_read, 1'b1);
        check("t2_addr_held", flash_mem_address, 23'h2ABCDE);
        wr = 1'b0;
        step();
        check("t2_read_drop", flash_mem_read, 1'b0);
        vld = 1'b1; rdata = $urandom;
        step();
        vld = 1'b0;
        step();

        // T3: two requests during WAIT_VALID, latest address wins
        f0 = n_flag;
        req = 1'b1; addr = 23'h000020;
        step();
        req = 1'b0;
        step();
        req = 1'b1; addr = 23'h000011;
        step();
        addr = 23'h000012;
        step();
        req = 1'b0; vld = 1'b1; rdata = $urandom;
        step();
        vld = 1'b0;
        check("t3_next_read", flash_mem_read, 1'b1);
        check("t3_next_addr", flash_mem_address, 23'h12);
        step();
        vld = 1'b1; rdata = $urandom;
        step();
        vld = 1'b0;
        step();
        step();
        check("t3_pulses", n_flag - f0, 2);

        // T4: no data ever returned -> timeout after TMO cycles
        req = 1'b1; addr = 23'h000040;
        step();
        req = 1'b0;
        step();
        k = TMO + 50;
        for (int i = 1; i <= TMO + 50; i++) begin
            step();
            if (read_data_flag) begin
                k = i;
                break;
            end
        end
        check("t4_cycles", k, TMO);
        check("t4_data", flash_data, 32'h0);
        check("t4_err", timeout_err, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check("t4_err_sticky", timeout_err, 1'b1);

        // T5: reset during WAIT_VALID, late data ignored
        req = 1'b1; addr = 23'h000050;
        step();
        req = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #2;
        m_clear();
        check("t5_busy_async", busy, 1'b0);
        step();
        reset = 1'b0;
        f0 = n_flag;
        vld = 1'b1; rdata = 32'hDDDDCCCC;
        step();
        vld = 1'b0;
        step();
        check("t5_data", flash_data, 32'h0);
        check("t5_noflag", n_flag - f0, 0);
        check("t5_busy", busy, 1'b0);

        // T6: word returned whole, halves land in the expected sample order
        req = 1'b1; addr = 23'h000030;
        step();
        req = 1'b0;
        step();
        vld = 1'b1; rdata = 32'hDDDDCCCC;
        step();
        vld = 1'b0;
        check("t6_lo", flash_data[15:0], 16'hCCCC);
        check("t6_hi", flash_data[31:16], 16'hDDDD);
        step();

        // Randomized traffic: back-pressure, bursty requests, spurious valids
        for (int i = 0; i < 3000; i++) begin
            req   = ($urandom % 6) == 0;
            addr  = ADDR_W'($urandom);
            wr    = ($urandom % 3) == 0;
            vld   = m_outst ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
            rdata = $urandom;
            step();
        end

        // Drain any outstanding work
        req = 1'b0;
        wr  = 1'b0;
        for (int i = 0; i < 40 && m_inflight; i++) begin
            vld   = m_outst;
            rdata = $urandom;
            step();
        end
        vld = 1'b0;
        step();
        check("drain_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
